// File: rtl/hs_pipe_chain.sv
// Purpose: DEPTH valid/ready stages (MODE 0 forward registers, MODE 1 two-entry skid buffers) with flush and occupancy.
// Latency: DEPTH cycles from an accepted input beat to m_valid when draining freely; 1 beat/clk sustained.
// Backpressure: MODE 0 ready ripples combinationally from m_ready (holds DEPTH beats); MODE 1 ready is registered per stage (holds 2*DEPTH).
module hs_pipe_chain #(
  parameter int DW    = 8,
  parameter int DEPTH = 5,
  parameter int MODE  = 0,
  localparam int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [CNT_W-1:0] occupancy
);

  // Per-stage state: main entry (mv/md) and skid entry (sv/sd, MODE 1 only)
  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] sv;
  logic [DW-1:0]    md [DEPTH];
  logic [DW-1:0]    sd [DEPTH];

  // rdy[k] is stage k's upstream ready; rdy[k+1] is its downstream ready
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] up_vld;
  logic [DW-1:0]    up_dat [DEPTH];
  logic             live;
  logic             s_xfer;
  logic             m_xfer;

  // Ready chain, evaluated from the output end back toward the input
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = m_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (MODE == 1) rdy[k] = ~sv[k];
      else           rdy[k] = ~mv[k] | rdy[k+1];
    end
  end

  generate
    if (MODE == 1) begin : g_live
      logic run;
      // Registered enable: keeps the registered s_ready low until the first edge after reset
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
      end
      assign live = run;
    end else begin : g_live
      assign live = rst;
    end
  endgenerate

  assign s_ready = rdy[0] & live & ~flush;
  assign s_xfer  = s_valid & s_ready;
  assign m_valid = mv[DEPTH-1];
  assign m_data  = md[DEPTH-1];
  assign m_xfer  = m_valid & m_ready;

  // Upstream view of each stage: the source for stage 0, the previous stage's main entry otherwise
  always_comb begin
    up_vld = '0;
    for (int k = 0; k < DEPTH; k++) up_dat[k] = '0;
    up_vld[0] = s_xfer;
    up_dat[0] = s_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_vld[k] = mv[k-1];
      up_dat[k] = md[k-1];
    end
  end

  // Stage storage: capture on upstream transfer, drain (or refill from skid) on downstream transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= '0;
      sv <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        md[k] <= '0;
        sd[k] <= '0;
      end
    end else if (flush) begin
      mv <= '0;
      sv <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (MODE == 1) begin
          if (up_vld[k] && rdy[k]) begin
            if (!mv[k] || rdy[k+1]) begin
              mv[k] <= 1'b1;
              md[k] <= up_dat[k];
            end else begin
              sv[k] <= 1'b1;
              sd[k] <= up_dat[k];
            end
          end else if (rdy[k+1]) begin
            if (sv[k]) begin
              md[k] <= sd[k];
              sv[k] <= 1'b0;
            end else begin
              mv[k] <= 1'b0;
            end
          end
        end else begin
          if (up_vld[k] && rdy[k]) begin
            mv[k] <= 1'b1;
            md[k] <= up_dat[k];
          end else if (rdy[k+1]) begin
            mv[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Beat count: +1 per accepted input, -1 per delivered output, cleared by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (s_xfer && !m_xfer) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (m_xfer && !s_xfer) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hs_pipe_chain.sv
`timescale 1ns/1ps
module tb_hs_pipe_chain;

  localparam int NI = 4;

  function automatic int dep_of(input int i);
    return (i < 2) ? 5 : 1;
  endfunction
  function automatic int mode_of(input int i);
    return i % 2;
  endfunction
  function automatic int cap_of(input int i);
    return (mode_of(i) == 1) ? 2 * dep_of(i) : dep_of(i);
  endfunction
  function automatic string nm(input string s, input int i);
    return $sformatf("%s[dut%0d D=%0d M=%0d]", s, i, dep_of(i), mode_of(i));
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush   [NI];
  logic       s_valid [NI];
  logic       s_ready [NI];
  logic [7:0] s_data  [NI];
  logic       m_valid [NI];
  logic       m_ready [NI];
  logic [7:0] m_data  [NI];
  logic [7:0] occ     [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = dep_of(g);
    localparam int M  = mode_of(g);
    localparam int CW = $clog2(2 * D + 1);
    logic [CW-1:0] occ_w;
    hs_pipe_chain #(.DW(8), .DEPTH(D), .MODE(M)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .s_valid   (s_valid[g]),
      .s_ready   (s_ready[g]),
      .s_data    (s_data[g]),
      .m_valid   (m_valid[g]),
      .m_ready   (m_ready[g]),
      .m_data    (m_data[g]),
      .occupancy (occ_w)
    );
    assign occ[g] = 8'(occ_w);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one FIFO of accepted beats per instance
  logic [7:0] mdl [NI][1024];
  int         wp [NI];
  int         rp [NI];
  int         out_cnt [NI];
  logic [7:0] last_out [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        chk(nm("rst_m_valid", i), int'(m_valid[i]), 0);
        chk(nm("rst_m_data", i), int'(m_data[i]), 0);
        chk(nm("rst_occ", i), int'(occ[i]), 0);
        chk(nm("rst_s_ready", i), int'(s_ready[i]), 0);
        rp[i] = wp[i];
      end else begin
        chk(nm("occupancy", i), int'(occ[i]), wp[i] - rp[i]);
        chk(nm("occ_le_cap", i), int'(int'(occ[i]) <= cap_of(i)), 1);
        if (m_valid[i]) begin
          chk(nm("m_valid_has_beat", i), int'(wp[i] > rp[i]), 1);
          if (wp[i] > rp[i])
            chk(nm("m_data_order", i), int'(m_data[i]), int'(mdl[i][rp[i] % 1024]));
        end
        if (flush[i]) chk(nm("flush_s_ready", i), int'(s_ready[i]), 0);
        if (m_valid[i] && m_ready[i] && wp[i] > rp[i]) begin
          last_out[i] = m_data[i];
          out_cnt[i]++;
          rp[i]++;
        end
        if (s_valid[i] && s_ready[i]) begin
          mdl[i][wp[i] % 1024] = s_data[i];
          wp[i]++;
        end
        if (flush[i]) rp[i] = wp[i];
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d);
    int t;
    t = 0;
    s_valid[i] = 1'b1;
    s_data[i]  = d;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready[i] && t < 200);
    if (!s_ready[i]) chk(nm("send_timeout", i), int'(s_ready[i]), 1);
    @(posedge clk);
    #1;
    s_valid[i] = 1'b0;
  endtask

  task automatic rst_release(input int i);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    if (mode_of(i) == 0) chk(nm("s_ready_at_release", i), int'(s_ready[i]), 1);
    else                 chk(nm("s_ready_before_first_edge", i), int'(s_ready[i]), 0);
    @(posedge clk);
    #1;
    chk(nm("s_ready_after_first_edge", i), int'(s_ready[i]), 1);
  endtask

  task automatic test_stream(input int i);
    int fs, fm, lm, nmv, t, base;
    sync();
    fs = -1; fm = -1; lm = -1; nmv = 0; t = 0; base = out_cnt[i];
    m_ready[i] = 1'b1;
    fork
      begin
        for (int k = 1; k <= 20; k++) send(i, 8'(2 * k));
      end
      begin
        while (nmv < 20 && t < 300) begin
          @(negedge clk);
          t++;
          if (fs < 0 && s_valid[i] && s_ready[i]) fs = t;
          if (m_valid[i]) begin
            if (fm < 0) fm = t;
            lm = t;
            nmv++;
          end
          if (fs >= 0 && t == fs + dep_of(i) + 5)
            chk(nm("stream_occ_steady", i), int'(occ[i]), dep_of(i));
        end
      end
    join
    sync();
    chk(nm("stream_latency", i), fm - fs, dep_of(i));
    chk(nm("stream_span", i), lm - fm, 19);
    chk(nm("stream_beats", i), out_cnt[i] - base, 20);
    chk(nm("stream_last", i), int'(last_out[i]), 40);
    m_ready[i] = 1'b0;
  endtask

  task automatic test_bp(input int i);
    int acc, cont, tail, base, w, t;
    sync();
    acc = 0; cont = 0; tail = 0; base = out_cnt[i]; w = 4 * cap_of(i);
    m_ready[i] = 1'b0;
    s_valid[i] = 1'b1;
    s_data[i]  = 8'(2);
    for (int k = 0; k < 4 * cap_of(i) + 10; k++) begin
      @(negedge clk);
      if (s_ready[i]) acc++;
      @(posedge clk);
      #1;
      s_data[i] = 8'(2 * (acc + 1));
    end
    @(negedge clk);
    chk(nm("bp_accepted", i), acc, cap_of(i));
    chk(nm("bp_occ", i), int'(occ[i]), cap_of(i));
    chk(nm("bp_s_ready_low", i), int'(s_ready[i]), 0);
    sync();
    m_ready[i] = 1'b1;
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      if (m_valid[i]) cont++;
      if (s_ready[i]) begin
        acc++;
        if (k >= w - cap_of(i)) tail++;
      end
      @(posedge clk);
      #1;
      s_data[i] = 8'(2 * (acc + 1));
    end
    chk(nm("bp_release_out_rate", i), cont, w);
    chk(nm("bp_resume_in_rate", i), tail, cap_of(i));
    chk(nm("bp_out_count", i), out_cnt[i] - base, w);
    chk(nm("bp_last_out", i), int'(last_out[i]), 2 * w);
    s_valid[i] = 1'b0;
    t = 0;
    while (occ[i] != 8'd0 && t < w + 20) begin
      @(negedge clk);
      t++;
    end
    chk(nm("bp_drained", i), int'(occ[i]), 0);
    sync();
    m_ready[i] = 1'b0;
  endtask

  task automatic test_rand(input int i);
    int base, t;
    sync();
    base = out_cnt[i];
    t = 0;
    m_ready[i] = 1'b1;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          int g;
          g = int'($urandom_range(0, 2));
          if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
          send(i, 8'($urandom));
        end
      end
      begin
        while (out_cnt[i] - base < 200 && t < 3000) begin
          @(posedge clk);
          #1;
          m_ready[i] = ~m_ready[i];
          t++;
        end
      end
    join
    sync();
    chk(nm("rand_delivered", i), out_cnt[i] - base, 200);
    m_ready[i] = 1'b0;
  endtask

  task automatic test_flush(input int i);
    int n, fs, fm, nmv;
    logic [7:0] dat;
    sync();
    n = (cap_of(i) < 3) ? cap_of(i) : 3;
    m_ready[i] = 1'b0;
    for (int k = 0; k < n; k++) send(i, 8'(16 + k));
    @(negedge clk);
    chk(nm("flush_prefill_occ", i), int'(occ[i]), n);
    sync();
    flush[i]   = 1'b1;
    s_valid[i] = 1'b1;
    s_data[i]  = 8'h77;
    @(negedge clk);
    chk(nm("flush_cycle_s_ready", i), int'(s_ready[i]), 0);
    sync();
    flush[i]   = 1'b0;
    s_valid[i] = 1'b0;
    chk(nm("flush_m_valid", i), int'(m_valid[i]), 0);
    chk(nm("flush_occ", i), int'(occ[i]), 0);
    m_ready[i] = 1'b1;
    fs = -1; fm = -1; nmv = 0; dat = 8'h00;
    fork
      send(i, 8'h5A);
      begin
        for (int t = 1; t <= 3 * dep_of(i) + 10; t++) begin
          @(negedge clk);
          if (fs < 0 && s_valid[i] && s_ready[i]) fs = t;
          if (m_valid[i]) begin
            if (fm < 0) begin
              fm  = t;
              dat = m_data[i];
            end
            nmv++;
          end
        end
      end
    join
    chk(nm("post_flush_latency", i), fm - fs, dep_of(i));
    chk(nm("post_flush_data", i), int'(dat), 8'h5A);
    chk(nm("post_flush_single_beat", i), nmv, 1);
    sync();
    m_ready[i] = 1'b0;
  endtask

  task automatic test_rst_mid(input int i);
    int n, nmv;
    sync();
    n = (cap_of(i) < 4) ? cap_of(i) : 4;
    m_ready[i] = 1'b0;
    for (int k = 0; k < n; k++) send(i, 8'(100 + k));
    @(negedge clk);
    chk(nm("rst_prefill_occ", i), int'(occ[i]), n);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk(nm("async_rst_m_valid", i), int'(m_valid[i]), 0);
    chk(nm("async_rst_m_data", i), int'(m_data[i]), 0);
    chk(nm("async_rst_occ", i), int'(occ[i]), 0);
    chk(nm("async_rst_s_ready", i), int'(s_ready[i]), 0);
    @(posedge clk);
    rst_release(i);
    m_ready[i] = 1'b1;
    nmv = 0;
    for (int t = 0; t < 2 * dep_of(i) + 5; t++) begin
      @(negedge clk);
      if (m_valid[i]) nmv++;
    end
    chk(nm("no_stale_beat", i), nmv, 0);
    sync();
    m_ready[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      flush[i]    = 1'b0;
      s_valid[i]  = 1'b0;
      s_data[i]   = 8'h00;
      m_ready[i]  = 1'b0;
      wp[i]       = 0;
      rp[i]       = 0;
      out_cnt[i]  = 0;
      last_out[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk(nm("reset_occ", i), int'(occ[i]), 0);
      chk(nm("reset_m_valid", i), int'(m_valid[i]), 0);
      rst_release(i);
      test_stream(i);
      test_bp(i);
      test_rand(i);
      test_flush(i);
      test_rst_mid(i);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
